// File: rtl/sprite_ram_writer.sv
// Sprite RAM write side: accepts a valid/ready stream of 24-bit RGB pixels,
// quantises each one to a colour index and writes one full sprite frame into
// the RAM write port in raster order at linear addresses 0..N-1.
//
// Handshake: a pixel moves on a rising edge where in_valid && in_ready.
// in_ready is a pure function of state (high only in LOAD) and never depends
// on in_valid. The source may hold in_valid low for any number of cycles; the
// pixel count simply holds, so addresses stay contiguous across gaps.
module sprite_ram_writer #(
  parameter int                SPRITE_W    = 32,
  parameter int                SPRITE_H    = 32,
  parameter int                ADDR_W      = 10,
  parameter int                COLOR_W     = 6,
  parameter logic [23:0]       KEY_RGB     = 24'hFF00FF,
  parameter logic [COLOR_W-1:0] TRANSP_CODE = 6'd0,
  parameter logic [COLOR_W-1:0] ALT_CODE    = 6'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [23:0]        in_rgb,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [COLOR_W-1:0] wdata,
  output logic               busy,
  output logic               done
);

  localparam int                N         = SPRITE_W * SPRITE_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  // LOAD accepts pixels, LAST carries the final write, DONE pulses done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [COLOR_W-1:0] wdata_q, wdata_d;

  // Colour index for one pixel: keep the two MSBs of each channel, reserve
  // the transparent code for the key colour only.
  function automatic logic [COLOR_W-1:0] quantise(input logic [23:0] rgb);
    logic [5:0] q;
    q = {rgb[23:22], rgb[15:14], rgb[7:6]};
    if (rgb == KEY_RGB) begin
      return TRANSP_CODE;
    end else if (COLOR_W'(q) == TRANSP_CODE) begin
      return ALT_CODE;
    end else begin
      return COLOR_W'(q);
    end
  endfunction

  // Next state, pixel count and the registered write stage.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          waddr_d = count_q;
          wdata_d = quantise(in_rgb);
          if (count_q == LAST_ADDR) begin
            // count stays at N-1; the next start clears it
            state_d = S_LAST;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_LAST: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel drops any pixel handshaken at this edge and suppresses done.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      count_d = count_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // State and write-port registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

endmodule
